// File: rtl/apb_mem_slave.sv
// APB4 memory slave: parametrised width/depth, byte-lane strobes, wait states,
// out-of-range error response and a read path registered at the setup edge.

module apb_mem_lane #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             gclk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    // No reset on the array: contents are undefined until written.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge gclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]      addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic                  write;
        logic                  err;
    } req_t;

    state_t                           state;
    logic [CNT_W-1:0]                 cnt;
    req_t                             req_q;
    logic                             setup;
    logic                             oor;
    logic                             commit;
    logic [STRB_WIDTH-1:0][7:0]       rd_lane;

    assign setup   = PSEL & ~PENABLE;
    assign oor     = {1'b0, PADDR} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign PREADY  = (state == ACCESS) & (cnt == '0) & PSEL & PENABLE & ~PRESET;
    assign PSLVERR = PREADY & req_q.err;
    // Commit uses the latched request so bus changes during ACCESS are inert.
    assign commit  = PREADY & req_q.write & ~req_q.err;

    genvar i;
    generate
        for (i = 0; i < STRB_WIDTH; i++) begin : g_lane
            apb_mem_lane #(
                .DEPTH (DEPTH),
                .IDX_W (IDX_W)
            ) u_lane (
                .gclk  (PCLK),
                .we    (commit & req_q.strb[i]),
                .waddr (req_q.addr),
                .wdata (req_q.wdata[8*i +: 8]),
                .raddr (PADDR[IDX_W-1:0]),
                .rdata (rd_lane[i])
            );
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            req_q  <= '0;
            PRDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        req_q.addr  <= PADDR[IDX_W-1:0];
                        req_q.wdata <= PWDATA;
                        req_q.strb  <= PSTRB;
                        req_q.write <= PWRITE;
                        req_q.err   <= oor;
                        cnt         <= CNT_W'(WAIT_STATES);
                        state       <= ACCESS;
                        if (!PWRITE) PRDATA <= oor ? '0 : rd_lane;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                        else           state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: one DUT with no wait states, one with two, sharing the bus.

module tb_apb_mem_slave;
    logic        clk = 0;
    logic        preset = 1;
    logic        psel0 = 0, psel2 = 0, penable = 0, pwrite = 0;
    logic [7:0]  paddr = 0;
    logic [31:0] pwdata = 0;
    logic [3:0]  pstrb = 0;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2;
    int          total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

    function automatic logic rdy(input int s);
        return (s == 2) ? pready2 : pready0;
    endfunction

    // One full transfer; bus fields are scrambled during ACCESS on purpose.
    task automatic xfer(input int s, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int n, output logic early);
        @(posedge clk); #1;
        psel0 = (s == 0); psel2 = (s == 2); penable = 0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = st;
        @(negedge clk); early = rdy(s);
        @(posedge clk); #1;
        penable = 1; paddr = a ^ 8'h01; pwdata = ~d; pstrb = ~st;
        n = 2; rd = '0; err = 0;
        forever begin
            @(negedge clk);
            if (rdy(s)) begin
                rd  = (s == 2) ? prdata2 : prdata0;
                err = (s == 2) ? pslverr2 : pslverr0;
                break;
            end
            if (n > 20) begin n = -1; break; end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel0 = 0; psel2 = 0; penable = 0;
    endtask

    task automatic test_reset();
        preset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin bad++; $display("FAIL reset_flags0 got rdy=%b err=%b want 0 0", pready0, pslverr0); end
        total++; if (prdata0 !== 32'h0) begin bad++; $display("FAIL reset_prdata0 got %h want 0", prdata0); end
        total++; if (prdata2 !== 32'h0 || pready2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 got prdata=%h rdy=%b want 0 0", prdata2, pready2); end
        @(posedge clk); #1; preset = 0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err, early; int n;
        xfer(0, 1, 8'd3, 32'hDEADBEEF, 4'hF, rd, err, n, early);
        total++; if (n !== 2 || early !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL basic_wr got n=%0d early=%b err=%b want 2 0 0", n, early, err); end
        xfer(0, 0, 8'd3, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin bad++; $display("FAIL basic_rd got %h err=%b want deadbeef 0", rd, err); end
        total++; if (n !== 2 || early !== 1'b0) begin bad++; $display("FAIL basic_rd_len got n=%0d early=%b want 2 0", n, early); end
        idle();
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err, early; int n;
        xfer(0, 1, 8'd3, 32'h11223344, 4'b0101, rd, err, n, early);
        xfer(0, 0, 8'd3, 32'h0, 4'hF, rd, err, n, early);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL strobe_mix got %h want de22be44", rd); end
        xfer(0, 1, 8'd3, 32'hFFFFFFFF, 4'h0, rd, err, n, early);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL strobe_zero_err got %b want 0", err); end
        xfer(0, 0, 8'd3, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL strobe_zero got %h want de22be44", rd); end
        idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err, early; int n;
        xfer(0, 1, 8'd4, 32'h0BADF00D, 4'hF, rd, err, n, early);
        xfer(0, 1, 8'd20, 32'h00000005, 4'hF, rd, err, n, early);
        total++; if (err !== 1'b1 || n !== 2) begin bad++; $display("FAIL oor_wr got err=%b n=%0d want 1 2", err, n); end
        xfer(0, 0, 8'd20, 32'h0, 4'h0, rd, err, n, early);
        total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL oor_rd got err=%b rd=%h want 1 0", err, rd); end
        xfer(0, 0, 8'd4, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'h0BADF00D || err !== 1'b0) begin bad++; $display("FAIL oor_alias got %h err=%b want 0badf00d 0", rd, err); end
        idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err, early; int n;
        xfer(2, 1, 8'd5, 32'hCAFEF00D, 4'hF, rd, err, n, early);
        total++; if (n !== 4 || early !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL ws_wr got n=%0d early=%b err=%b want 4 0 0", n, early, err); end
        xfer(2, 0, 8'd5, 32'h0, 4'h0, rd, err, n, early);
        total++; if (n !== 4 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL ws_rd got n=%0d rd=%h want 4 cafef00d", n, rd); end
        idle();
    endtask

    task automatic test_no_setup();
        logic [31:0] rd; logic err, early; int n; int seen = 0;
        @(posedge clk); #1;
        psel0 = 1; penable = 1; pwrite = 1; paddr = 8'd3; pwdata = 32'h0; pstrb = 4'hF;
        repeat (3) begin @(negedge clk); if (pready0) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL nosetup_ready got %0d want 0", seen); end
        idle();
        xfer(0, 0, 8'd3, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL nosetup_mem got %h want de22be44", rd); end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err, early; int n; int seen = 0;
        xfer(2, 1, 8'd1, 32'h01010101, 4'hF, rd, err, n, early);
        idle();
        @(posedge clk); #1;
        psel2 = 1; penable = 0; pwrite = 1; paddr = 8'd1; pwdata = 32'hFFFF0000; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1;
        @(negedge clk); if (pready2) seen++;
        @(posedge clk); #1; psel2 = 0; penable = 0;
        @(negedge clk); if (pready2) seen++;
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ready got %0d want 0", seen); end
        xfer(2, 0, 8'd1, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'h01010101 || n !== 4) begin bad++; $display("FAIL abort_mem got %h n=%0d want 01010101 4", rd, n); end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, early; int n;
        xfer(2, 1, 8'd2, 32'hAAAA5555, 4'hF, rd, err, n, early);
        idle();
        @(posedge clk); #1;
        psel2 = 1; penable = 0; pwrite = 1; paddr = 8'd2; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1;
        @(posedge clk); #1;
        @(posedge clk); #1; preset = 1;
        @(negedge clk);
        total++; if (pready2 !== 1'b0 || pslverr2 !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got rdy=%b err=%b want 0 0", pready2, pslverr2); end
        @(posedge clk); #1; preset = 0; psel2 = 0; penable = 0;
        @(negedge clk);
        total++; if (prdata2 !== 32'h0) begin bad++; $display("FAIL rst_mid_prdata got %h want 0", prdata2); end
        xfer(2, 0, 8'd2, 32'h0, 4'h0, rd, err, n, early);
        total++; if (rd !== 32'hAAAA5555 || n !== 4) begin bad++; $display("FAIL rst_mid_mem got %h n=%0d want aaaa5555 4", rd, n); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err, early; int n; int c0, c1;
        logic [31:0] vals [4] = '{32'h10203040, 32'h55AA55AA, 32'h0F0F0F0F, 32'h89ABCDEF};
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            xfer(0, 1, 8'(k), vals[k], 4'hF, rd, err, n, early);
            total++; if (n !== 2) begin bad++; $display("FAIL b2b_wr%0d got n=%0d want 2", k, n); end
        end
        for (int k = 0; k < 4; k++) begin
            xfer(0, 0, 8'(k), 32'h0, 4'h0, rd, err, n, early);
            total++; if (rd !== vals[k] || n !== 2) begin bad++; $display("FAIL b2b_rd%0d got %h n=%0d want %h 2", k, rd, n, vals[k]); end
        end
        c1 = cyc;
        total++; if (c1 - c0 !== 16) begin bad++; $display("FAIL b2b_cycles got %0d want 16", c1 - c0); end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_out_of_range();
        test_wait_states();
        test_no_setup();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave: a successor to the team's fixed 8-bit APB memory slaves, generalised in address/data width and depth. Adds configurable wait states, byte-lane write strobes, error response on out-of-range access, and a registered read path. Sits behind the APB master/decoder as one PSEL target in the peripheral subsystem.

## Interface
- ADDR_WIDTH, 8, width of PADDR (word address, not byte address).
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be a multiple of 8.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.
- WAIT_STATES, 0, number of PREADY-low access cycles before completion; 0..15.
- Derived: STRB_WIDTH = DATA_WIDTH/8; CNT_W = max(1, clog2(WAIT_STATES+1)).

Ports:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  word address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_WIDTH  write byte-lane enables; bit i covers PWDATA[8i+7:8i].
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; valid only when PREADY=1.

## Operation
- States: IDLE, ACCESS.
- IDLE: on an edge where PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA, and PSTRB, plus err = (PADDR ≥ DEPTH); load the counter with WAIT_STATES; go to ACCESS.
  - Same edge, read without err: PRDATA ← mem[PADDR].
  - Same edge, read with err: PRDATA ← 0.
  - Same edge, write: PRDATA holds.
- IDLE with PSEL=1 and PENABLE=1 (no setup phase seen): ignored, PREADY stays 0, no state change.
- ACCESS with PSEL=1 and PENABLE=1:
  - Counter ≠ 0: PREADY=0; counter decrements each edge.
  - Counter = 0: PREADY=1 and PSLVERR=err. At that edge, a write without err updates each byte lane i of mem[addr] where PSTRB[i]=1; state returns to IDLE.
- ACCESS with PSEL=0: transfer aborted. Return to IDLE; no memory write; PREADY never asserted.
- PREADY is combinational: (state==ACCESS) & (cnt==0) & PSEL & PENABLE & !PRESET.
- PSLVERR = PREADY & err; 0 at all other times.
- Out-of-range write: memory unchanged; PSLVERR=1.
- Out-of-range read: PRDATA=0; PSLVERR=1.
- Write with PSTRB=0: no memory change, PSLVERR=0.
- PSTRB is ignored on reads.
- Memory contents are not cleared by reset (undefined until written).

## Timing
- Reset values: state IDLE, cnt 0, PRDATA 0, PREADY 0, PSLVERR 0.
- PRESET asserted forces PREADY=0 and PSLVERR=0 combinationally in the same cycle.
- PRESET during ACCESS: the pending write is discarded and the FSM returns to IDLE at that edge.
- Transfer length = 2 + WAIT_STATES cycles (setup + access); WAIT_STATES=0 completes in the first access cycle.
- PRDATA is stable from the cycle after the setup edge through completion, and holds afterward until the next read setup.
- Back-to-back transfers: a new setup phase in the cycle immediately after completion is accepted; there are no dead cycles.
- Read-after-write to the same address in consecutive transfers returns the new data: the write commits at the completion edge, before the next setup edge.
- PADDR, PWDATA, and PSTRB changes during ACCESS have no effect (values latched at setup).

## Test plan
- DATA_WIDTH=32, DEPTH=16, WAIT_STATES=0. Write 0xDEADBEEF to addr 3 with PSTRB=4'hF, then read addr 3 → PREADY high in each transfer's 2nd cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte strobes. Addr 3 holds 0xDEADBEEF; write 0x11223344 with PSTRB=4'b0101, then read addr 3 → 0xDE22BE44.
- WAIT_STATES=2. Single write and single read → PREADY low for 2 access cycles and high on the 3rd; total transfer is 4 cycles; data correct.
- Out of range (DEPTH=16). Write 0x5 to addr 20, then read addr 20 → PSLVERR=1 on both completions; read PRDATA=0; read of addr 4 (20 mod 16) is unchanged.
- Abort and reset. With WAIT_STATES=2, drop PSEL mid-access of a write to addr 1 → no write occurs. Assert PRESET during a write access → PREADY=0, FSM returns to IDLE, addr unchanged, PRDATA=0 after reset.
- Back-to-back. Four consecutive writes to addrs 0–3 followed by four reads with no idle cycles → all four values are read back; PREADY pulses every 2nd cycle.
